instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch unit for the 16-bit processor. It holds the program counter and runs a request/valid handshake with instruction memory. Each fetched word is presented on `D` with a one-cycle `read` strobe, so the instruction register's load port connects directly. It sits between the control unit (fetch/jump commands) and instruction memory, on the producer side of the IR load interface.

## Interface
Parameters:
- `ADDR_W`, 8: program counter / memory address width.
- `DATA_W`, 16: instruction width; matches the IR data input.
- `RESET_PC`, 0: program counter value after reset.
- `TIMEOUT`, 15: maximum cycles to wait for `mem_valid` before aborting a fetch; range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: control unit requests the next instruction fetch.
- `jump_en` input 1: load the PC from `jump_addr`.
- `jump_addr` input ADDR_W: jump target.
- `mem_addr` output ADDR_W: instruction memory address; stable while `mem_req`=1.
- `mem_req` output 1: memory read request, held until accepted or timed out.
- `mem_data` input DATA_W: memory read data; valid when `mem_valid`=1.
- `mem_valid` input 1: memory returns data this cycle.
- `D` output DATA_W: fetched instruction to the IR.
- `read` output 1: IR load strobe, one cycle, aligned with valid `D`.
- `pc` output ADDR_W: current program counter (address of the next fetch).
- `busy` output 1: fetch in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse, same cycle as `read`.
- `err` output 1: one-cycle pulse on fetch timeout.

## Operation
- All outputs are registered. Reset values: `pc`=RESET_PC, `mem_addr`=0, `mem_req`=0, `D`=0, `read`=0, `done`=0, `busy`=0, `err`=0. The wait counter resets to 0 and the state resets to IDLE.
- States: IDLE, WAIT, LOAD.
- IDLE, `jump_en`=1, `start`=0: `pc`←`jump_addr`; stay in IDLE.
- IDLE, `start`=1:
  - Fetch address is `jump_addr` if `jump_en`=1, otherwise `pc`; jump has priority and is fetched immediately.
  - `mem_addr`←fetch address, `pc`←fetch address, `mem_req`←1, wait counter←0, go to WAIT.
- WAIT, `mem_valid`=1:
  - `D`←`mem_data`, `read`←1, `done`←1, `mem_req`←0.
  - `pc`←`pc`+1 modulo 2^ADDR_W (wraps from all-ones to 0).
  - Go to LOAD.
- WAIT, `mem_valid`=0:
  - Counter increments.
  - When the counter reaches TIMEOUT-1 with no `mem_valid`: `mem_req`←0, `err`←1, `pc` unchanged, `D` unchanged, go to IDLE.
- LOAD: `read` and `done` are high for this single cycle; next state is IDLE.
- In LOAD, `read`←0 and `done`←0 on the exiting edge. `err` likewise clears after one cycle.
- `start` and `jump_en` are ignored in WAIT and LOAD. Commands are not queued.
- `mem_valid` is ignored outside WAIT.
- `D` holds its last fetched value until the next successful fetch.
- `rst` during WAIT or LOAD: the in-flight fetch is abandoned, and all registers take their reset values on that edge.

## Timing
- `start` sampled at edge n → `mem_req`=1 and `mem_addr` valid from edge n through the accepting edge.
- `mem_valid` sampled at edge k (k ≥ n+1) → `read`, `done`, and the new `D` are high/valid for the cycle after edge k. `pc` is updated on that same edge.
- Minimum start-to-`read` latency is 2 cycles, when `mem_valid` arrives on the first WAIT edge.
- Back-to-back fetches: `start` asserted during LOAD is ignored. The earliest accepted `start` is the IDLE cycle after LOAD, which gives a throughput of one instruction per 3 cycles minimum.
- Timeout: `err` is high for the cycle after the TIMEOUT-th WAIT edge without `mem_valid`.
- `busy` is high from the edge after `start` until the edge that returns to IDLE.

## Structure
- Shared package `cpu_pkg`: fetch state encoding (IDLE/WAIT/LOAD), and default `ADDR_W`/`DATA_W` constants shared with the IR and control unit.
- One sub-module: `pc_register` (synchronous reset to RESET_PC, load port, increment port, wraps modulo 2^ADDR_W).
- The FSM, handshake, and timeout counter live in `instr_fetch_unit`.

## Test plan
- Reset then `start`; memory returns 16'hA5C3 one cycle later at `mem_addr`=0:
  - `read`=1 and `D`=16'hA5C3 for exactly one cycle, 2 cycles after `start`.
  - `pc`=1 afterwards.
- `jump_en`=1, `jump_addr`=8'h40 alone in IDLE, then `start` with a memory delay of 3 cycles:
  - `mem_addr`=8'h40 with `mem_req` held for 3 cycles.
  - `read` one cycle after `mem_valid`; final `pc`=8'h41.
- `jump_en` and `start` together, `jump_addr`=8'hFF:
  - Fetch occurs at address 8'hFF.
  - `pc` wraps to 8'h00 after the load.
- `mem_valid` never asserted, TIMEOUT=15:
  - `err` pulses once, 15 cycles after `mem_req` rises.
  - `mem_req` drops; `pc` and `D` unchanged; `read` never asserted.
- `start` pulsed during WAIT and LOAD: ignored, with exactly one `read` per accepted fetch.
- `rst` asserted mid-WAIT: on the next edge all outputs return to their reset values, `pc`=RESET_PC, and no `read` is issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch state encoding and default datapath widths shared across the CPU
package cpu_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: request/valid handshake between the fetch unit and instruction memory
interface instr_fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
    parameter int DATA_W = cpu_pkg::DATA_W_DEF
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_data,
        output mem_valid
    );

endinterface

// File: rtl/instr_fetch_unit_pc_register.sv
// pc_register: program counter with load and increment ports, wrapping modulo 2^ADDR_W
module pc_register #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // load wins over increment; increment wraps naturally at the register width
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and memory handshake FSM producing one-cycle IR load strobes
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_addr,
    instr_fetch_unit_if.master  mem,
    output logic [DATA_W-1:0]   D,
    output logic                read,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t      state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              req_q, req_n;
    logic [DATA_W-1:0] d_n;
    logic              read_n, done_n, err_n, busy_n;
    logic              pc_load, pc_inc;
    logic [ADDR_W-1:0] fetch_addr;

    assign mem.mem_addr = addr_q;
    assign mem.mem_req  = req_q;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (fetch_addr),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // next state and next registered outputs; strobes default low so they last one cycle
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr_q;
        req_n      = req_q;
        d_n        = D;
        read_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        fetch_addr = jump_en ? jump_addr : pc;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_n  = fetch_addr;
                    pc_load = 1'b1;
                    req_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT;
                end else if (jump_en) begin
                    pc_load = 1'b1;
                end
            end
            WAIT: begin
                if (mem.mem_valid) begin
                    d_n     = mem.mem_data;
                    read_n  = 1'b1;
                    done_n  = 1'b1;
                    req_n   = 1'b0;
                    pc_inc  = 1'b1;
                    state_n = LOAD;
                end else if (cnt == CNT_LAST) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            LOAD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end

    // state, counter and all registered outputs; reset abandons any in-flight fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            req_q  <= 1'b0;
            D      <= '0;
            read   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            req_q  <= req_n;
            D      <= d_n;
            read   <= read_n;
            done   <= done_n;
            err    <= err_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized fetches checked against a transaction-level model
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_addr = '0;
    logic [15:0] d;
    logic        read, busy, done, err;
    logic [7:0]  pc;

    int checks = 0;
    int failures = 0;

    logic [7:0]  pc_m;
    logic [15:0] d_m;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) mem_bus ();

    instr_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (8'h00),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .mem       (mem_bus),
        .D         (d),
        .read      (read),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'h00);
        check({tag, "_addr"}, 32'(mem_bus.mem_addr), 32'h00);
        check({tag, "_req"}, 32'(mem_bus.mem_req), 32'h0);
        check({tag, "_d"}, 32'(d), 32'h0);
        check({tag, "_read"}, 32'(read), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    // one fetch: start (optionally with jump), then dly WAIT edges without valid before data arrives
    task automatic fetch(input logic jmp, input logic [7:0] ja, input int dly, input logic [15:0] data);
        logic [7:0] exp_addr;
        exp_addr  = jmp ? ja : pc_m;
        start     = 1'b1;
        jump_en   = jmp;
        jump_addr = ja;
        tick();
        check("req_rise", 32'(mem_bus.mem_req), 32'h1);
        check("addr", 32'(mem_bus.mem_addr), 32'(exp_addr));
        check("busy_rise", 32'(busy), 32'h1);
        check("pc_at_start", 32'(pc), 32'(exp_addr));
        for (int i = 0; i < 256; i++) begin
            start          = 1'($urandom);
            jump_en        = 1'($urandom);
            jump_addr      = 8'($urandom);
            mem_bus.mem_valid = (i == dly);
            mem_bus.mem_data  = (i == dly) ? data : 16'($urandom);
            tick();
            if (i == dly) begin
                pc_m = 8'((32'(exp_addr) + 1) % 256);
                d_m  = data;
                check("read_hi", 32'(read), 32'h1);
                check("done_hi", 32'(done), 32'h1);
                check("d_new", 32'(d), 32'(d_m));
                check("pc_inc", 32'(pc), 32'(pc_m));
                check("req_drop", 32'(mem_bus.mem_req), 32'h0);
                check("err_lo_load", 32'(err), 32'h0);
                start             = 1'($urandom);
                jump_en           = 1'($urandom);
                mem_bus.mem_valid = 1'($urandom);
                tick();
                check("read_one_cycle", 32'(read), 32'h0);
                check("done_one_cycle", 32'(done), 32'h0);
                check("busy_after_load", 32'(busy), 32'h0);
                check("pc_after_load", 32'(pc), 32'(pc_m));
                break;
            end else if (i == TIMEOUT - 1) begin
                pc_m = exp_addr;
                check("err_hi", 32'(err), 32'h1);
                check("req_timeout", 32'(mem_bus.mem_req), 32'h0);
                check("pc_timeout", 32'(pc), 32'(pc_m));
                check("d_timeout", 32'(d), 32'(d_m));
                check("read_timeout", 32'(read), 32'h0);
                check("busy_timeout", 32'(busy), 32'h0);
                start             = 1'b0;
                jump_en           = 1'b0;
                mem_bus.mem_valid = 1'b0;
                tick();
                check("err_one_cycle", 32'(err), 32'h0);
                break;
            end else begin
                check("req_held", 32'(mem_bus.mem_req), 32'h1);
                check("addr_held", 32'(mem_bus.mem_addr), 32'(exp_addr));
                check("read_wait", 32'(read), 32'h0);
                check("err_wait", 32'(err), 32'h0);
            end
        end
        start             = 1'b0;
        jump_en           = 1'b0;
        mem_bus.mem_valid = 1'b0;
    endtask

    initial begin
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_data  = '0;
        pc_m = 8'h00;
        d_m  = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        check_idle_reset("reset");

        fetch(1'b0, 8'h00, 0, 16'hA5C3);

        jump_en   = 1'b1;
        jump_addr = 8'h40;
        tick();
        jump_en = 1'b0;
        pc_m    = 8'h40;
        check("jump_alone_pc", 32'(pc), 32'h40);
        check("jump_alone_busy", 32'(busy), 32'h0);
        check("jump_alone_req", 32'(mem_bus.mem_req), 32'h0);
        fetch(1'b0, 8'h00, 2, 16'h1234);
        check("pc_41", 32'(pc), 32'h41);

        fetch(1'b1, 8'hFF, 1, 16'hBEEF);
        check("pc_wrap", 32'(pc), 32'h00);

        fetch(1'b0, 8'h00, TIMEOUT + 5, 16'h0000);

        start = 1'b1;
        tick();
        start = 1'b0;
        mem_bus.mem_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = 16'hDEAD;
        tick();
        rst  = 1'b0;
        pc_m = 8'h00;
        d_m  = 16'h0000;
        check_idle_reset("rst_mid_wait");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_read_after_rst", 32'(read), 32'h0);
            check("idle_after_rst", 32'(busy), 32'h0);
        end
        mem_bus.mem_valid = 1'b0;

        for (int n = 0; n < 30; n++)
            fetch(1'($urandom), 8'($urandom), int'($urandom_range(0, TIMEOUT + 2)), 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
